// File: rtl/result_collector.sv
// result_collector
//   Serializes PE-array results into 32-bit writes to the result batch buffer.
//   Each accepted result becomes WORDS = RES_WIDTH/32 consecutive writes,
//   most-significant word first. A batch closes on result_last, or when the
//   buffer's last address is written. The unused tail is then zero-padded,
//   the collector idles 2 cycles, pulses task_done and waits for the
//   downstream buffer to drain (a Full rise then fall) before the next batch.
//
//   Optional feature macro: RESULT_COLLECTOR_PAD_FULL_EN
//     defined   : pad zeros through the last buffer address
//     undefined : pad zeros only to the end of the current 16-word line
//
// Ports
//   clk, reset          core clock, asynchronous active-high reset
//   result_valid/data/last, result_ready   PE result handshake
//   Full                downstream buffer draining
//   WrEn, WrAddr, WrDin registered buffer word write
//   task_done           one-cycle batch-complete pulse
//   batch_count         result count of the last closed batch
module result_collector #(
  parameter int RBB_WR_ADDR_WIDTH = 12,
  parameter int RBB_WR_DATA_WIDTH = 32,
  parameter int RES_WIDTH         = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         result_valid,
  input  logic [RES_WIDTH-1:0]         result_data,
  input  logic                         result_last,
  output logic                         result_ready,
  input  logic                         Full,
  output logic                         WrEn,
  output logic [RBB_WR_ADDR_WIDTH-1:0] WrAddr,
  output logic [RBB_WR_DATA_WIDTH-1:0] WrDin,
  output logic                         task_done,
  output logic [RBB_WR_ADDR_WIDTH:0]   batch_count
);

  localparam int AW    = RBB_WR_ADDR_WIDTH;
  localparam int DW    = RBB_WR_DATA_WIDTH;
  localparam int WORDS = RES_WIDTH / DW;
  localparam int CW    = $clog2(WORDS + 1);

  localparam logic [AW:0]   CAP     = (AW+1)'(1) << AW;
  localparam logic [AW:0]   WORDS_A = (AW+1)'(WORDS);
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_PAD     = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [RES_WIDTH-1:0] sr_q, sr_d;          // serializer shift register
  logic [CW-1:0]        cnt_q, cnt_d;        // words still to emit
  logic [AW-1:0]        addr_q, addr_d;      // next write address
  logic [AW:0]          alloc_q, alloc_d;    // words already claimed by accepts
  logic [AW:0]          nres_q, nres_d;      // accepted results this batch
  logic                 close_q, close_d;    // batch closes after serializer drains
  logic                 gap_q, gap_d;
  logic                 seen_full_q, seen_full_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [DW-1:0]        wr_din_q, wr_din_d;
  logic                 done_q, done_d;
  logic [AW:0]          bcnt_q, bcnt_d;

  logic pad_end;
  logic xfer;

`ifdef RESULT_COLLECTOR_PAD_FULL_EN
  assign pad_end = &addr_q;
`else
  assign pad_end = &addr_q[3:0];
`endif

  // A new result may load while the serializer emits its final word,
  // so back-to-back results stream without a bubble.
  assign result_ready = (state_q == S_COLLECT) && !close_q && (cnt_q <= CW'(1));
  assign xfer         = result_valid && result_ready;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    alloc_d     = alloc_q;
    nres_d      = nres_q;
    close_d     = close_q;
    gap_d       = gap_q;
    seen_full_d = seen_full_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_din_d    = '0;
    done_d      = 1'b0;
    bcnt_d      = bcnt_q;
    case (state_q)
      S_IDLE: begin
        addr_d      = '0;
        alloc_d     = '0;
        nres_d      = '0;
        close_d     = 1'b0;
        seen_full_d = 1'b0;
        if (!Full) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (cnt_q != '0) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_din_d  = sr_q[RES_WIDTH-1 -: DW];
          sr_d      = sr_q << DW;
          cnt_d     = cnt_q - CW'(1);
          addr_d    = addr_q + AW'(1);
          // Final word of the closing result: skip PAD if it lands on the pad end.
          if (cnt_q == CW'(1) && close_q) begin
            state_d = pad_end ? S_GAP : S_PAD;
            gap_d   = 1'b0;
          end
        end
        if (xfer) begin
          sr_d    = result_data;
          cnt_d   = WORDS_C;
          nres_d  = nres_q + (AW+1)'(1);
          alloc_d = alloc_q + WORDS_A;
          // A result whose last word fills the buffer closes the batch as if last.
          if (result_last || (alloc_q + WORDS_A == CAP)) close_d = 1'b1;
        end
      end
      S_PAD: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        addr_d    = addr_q + AW'(1);
        if (pad_end) begin
          state_d = S_GAP;
          gap_d   = 1'b0;
        end
      end
      S_GAP: begin
        gap_d = 1'b1;
        if (gap_q) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        bcnt_d  = nres_q;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (Full) seen_full_d = 1'b1;
        if (seen_full_q && !Full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      alloc_q     <= '0;
      nres_q      <= '0;
      close_q     <= 1'b0;
      gap_q       <= 1'b0;
      seen_full_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_din_q    <= '0;
      done_q      <= 1'b0;
      bcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      alloc_q     <= alloc_d;
      nres_q      <= nres_d;
      close_q     <= close_d;
      gap_q       <= gap_d;
      seen_full_q <= seen_full_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_din_q    <= wr_din_d;
      done_q      <= done_d;
      bcnt_q      <= bcnt_d;
    end
  end

  assign WrEn        = wr_en_q;
  assign WrAddr      = wr_addr_q;
  assign WrDin       = wr_din_q;
  assign task_done   = done_q;
  assign batch_count = bcnt_q;

endmodule

// File: tb/tb_result_collector.sv
// Randomized bench for result_collector with a queue-based write model.
module tb_result_collector;
  localparam int AW    = 12;
  localparam int RW    = 64;
  localparam int WORDS = RW / 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          result_valid, result_last, result_ready, Full;
  logic [RW-1:0] result_data;
  logic          WrEn, task_done;
  logic [AW-1:0] WrAddr;
  logic [31:0]   WrDin;
  logic [AW:0]   batch_count;

  always #5 clk = ~clk;

  result_collector #(.RBB_WR_ADDR_WIDTH(AW), .RBB_WR_DATA_WIDTH(32), .RES_WIDTH(RW)) dut (
    .clk(clk), .reset(reset), .result_valid(result_valid), .result_data(result_data),
    .result_last(result_last), .result_ready(result_ready), .Full(Full), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrDin(WrDin), .task_done(task_done), .batch_count(batch_count));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; logic fin; } wr_t;
  wr_t expq[$];
  int  next_addr = 0, nacc = 0, exp_cnt = 0;
  bit  closed = 0, td_pend = 0;
  int  drain_ph = 0;
  int  cyc = 0, td_due = 0, wr_total = 0, first_wr_cyc = 0, last_wr_cyc = 0;

  function automatic bit at_pad_end(int na);
`ifdef RESULT_COLLECTOR_PAD_FULL_EN
    return na == DEPTH;
`else
    return (na % 16) == 0;
`endif
  endfunction

  function automatic void model_accept(logic [RW-1:0] d, logic last);
    wr_t w;
    nacc++;
    for (int i = 0; i < WORDS; i++) begin
      w.a = AW'(next_addr); w.d = d[RW-1-32*i -: 32]; w.fin = 1'b0;
      expq.push_back(w);
      next_addr++;
    end
    if (last || next_addr == DEPTH) begin
      while (!at_pad_end(next_addr) && next_addr < DEPTH) begin
        w.a = AW'(next_addr); w.d = '0; w.fin = 1'b0;
        expq.push_back(w);
        next_addr++;
      end
      w = expq.pop_back();
      w.fin = 1'b1;
      expq.push_back(w);
      closed    = 1;
      exp_cnt   = nacc;
      next_addr = 0;
      nacc      = 0;
    end
  endfunction

  wr_t e;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      expq.delete();
      next_addr = 0; nacc = 0; closed = 0; td_pend = 0; drain_ph = 0;
    end else begin
      if (WrEn) begin
        wr_total++;
        if (expq.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
        else begin
          e = expq.pop_front();
          chk("wr_addr", 64'(WrAddr), 64'(e.a));
          chk("wr_data", 64'(WrDin), 64'(e.d));
          if (e.a == '0) first_wr_cyc = cyc;
          if (e.fin) begin td_pend = 1; td_due = cyc + 3; end
        end
        last_wr_cyc = cyc;
      end
      if (task_done || (td_pend && cyc == td_due)) begin
        chk("task_done", 64'(task_done), 64'(td_pend && cyc == td_due));
        if (task_done && td_pend) chk("batch_count", 64'(batch_count), 64'(exp_cnt));
        td_pend  = 0;
        drain_ph = 1;
      end else if (drain_ph == 1 && Full) drain_ph = 2;
      else if (drain_ph == 2 && !Full) begin drain_ph = 0; closed = 0; end
      if (closed) chk("ready_closed", 64'(result_ready), 64'd0);
      if (result_valid && result_ready) model_accept(result_data, result_last);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [RW-1:0] d, input logic last, input int prob);
    int g = 0;
    bit done = 0;
    result_data = d;
    result_last = last;
    while (!done && g < 3000) begin
      result_valid = ($urandom_range(99) < prob);
      @(negedge clk);
      done = result_valid && result_ready;
      @(posedge clk); #1;
      g++;
    end
    result_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int lim);
    int g = 0;
    @(negedge clk);
    while (!task_done && g < lim) begin @(negedge clk); g++; end
    if (!task_done) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n, input logic v);
    Full = 1'b1; result_valid = v; result_last = 1'b0;
    repeat (n) @(posedge clk);
    #1 Full = 1'b0; result_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic batch(input int n, input int prob, input bit noise, input bit use_last);
    for (int i = 0; i < n; i++) begin
      if (noise) Full = $urandom_range(1);
      send({$urandom, $urandom}, use_last && (i == n - 1), prob);
    end
    Full = 1'b0;
    wait_done(6000);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wren"},  64'(WrEn), 64'd0);
    chk({tag, "_waddr"}, 64'(WrAddr), 64'd0);
    chk({tag, "_wdin"},  64'(WrDin), 64'd0);
    chk({tag, "_done"},  64'(task_done), 64'd0);
    chk({tag, "_ready"}, 64'(result_ready), 64'd0);
    chk({tag, "_bcnt"},  64'(batch_count), 64'd0);
  endtask

  initial begin
    int base, g;
    reset = 1'b1; result_valid = 1'b0; result_last = 1'b0; result_data = '0; Full = 1'b0;
    #12 chk_zero("reset");
    @(posedge clk); #1 reset = 1'b0;
    result_valid = 1'b1; result_data = {$urandom, $urandom};
    @(negedge clk) chk("ready_first_edge", 64'(result_ready), 64'd0);
    result_valid = 1'b0;
    @(posedge clk); #1;

    // three known results, last on the third
    send(64'h1111_2222_3333_4444, 1'b0, 100);
    send(64'h5555_6666_7777_8888, 1'b0, 100);
    send(64'h9999_AAAA_BBBB_CCCC, 1'b1, 100);
    wait_done(6000);
    drain(5, 1'b0);

    // Full held high with valid asserted: nothing accepted, next batch at addr 0
    batch(5, 100, 0, 1);
    drain(100, 1'b1);

    // 8 results: final word lands on address 15, no padding
    batch(8, 100, 0, 1);
    drain(4, 1'b0);

    // randomized batches with Full noise during collection
    for (int b = 0; b < 6; b++) begin
      batch($urandom_range(1, 12), $urandom_range(30, 100), 1, 1);
      drain($urandom_range(1, 6), 1'b0);
    end

    // full buffer without last: streams without bubbles and closes at the top
    batch(DEPTH / WORDS, 100, 0, 0);
    chk("no_bubble_span", 64'(last_wr_cyc - first_wr_cyc), 64'(DEPTH - 1));
    drain(3, 1'b0);

    // reset while the third word of a batch is being written
    base = wr_total; g = 0;
    result_last = 1'b0;
    while (wr_total < base + 2 && g < 100) begin
      result_data = {$urandom, $urandom}; result_valid = 1'b1;
      @(negedge clk); @(posedge clk); #1;
      g++;
    end
    if (wr_total < base + 2) chk("midbatch_timeout", 64'd0, 64'd1);
    reset = 1'b1; result_valid = 1'b0;
    #1 chk_zero("midreset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    batch(4, 70, 0, 1);
    drain(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter RBB_WR_ADDR_WIDTH, default 12, meaning word address width into the result batch buffer (capacity 2^12 = 4096 words).
REQ-002 SHALL have parameter RBB_WR_DATA_WIDTH, default 32, meaning width of one buffer write word.
REQ-003 SHALL have parameter RES_WIDTH, default 64, meaning one PE result in bits; WORDS = RES_WIDTH/32 SHALL be 1, 2, 4, 8 or 16.
REQ-004 SHALL have port clk, input, 1 bit: the single core clock.
REQ-005 SHALL have port reset, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-006 SHALL have port result_valid, input, 1 bit: the PE array offers a result.
REQ-007 SHALL have port result_data, input, RES_WIDTH bits: the result payload.
REQ-008 SHALL have port result_last, input, 1 bit: the offered result is the last of the batch.
REQ-009 SHALL have port result_ready, output, 1 bit: the collector accepts the result this cycle.
REQ-010 SHALL have port Full, input, 1 bit: the downstream buffer is draining.
REQ-011 SHALL have port WrEn, output, 1 bit; port WrAddr, output, RBB_WR_ADDR_WIDTH bits; and port WrDin, output, 32 bits: the buffer word write.
REQ-012 SHALL have port task_done, output, 1 bit: a one-cycle batch-complete pulse.
REQ-013 SHALL have port batch_count, output, RBB_WR_ADDR_WIDTH+1 bits: the number of results in the last closed batch.

Function
REQ-014 States SHALL be IDLE, COLLECT, PAD, GAP, DONE and DRAIN.
- IDLE->COLLECT when Full=0.
REQ-015 A transfer SHALL occur when result_valid && result_ready.
- result_ready=1 only in COLLECT, when the serializer is empty or emitting its final word that cycle (back-to-back results, no bubble).
REQ-016 Each accepted result SHALL emit WORDS consecutive writes, WrEn=1, most-significant 32 bits first.
- WrAddr starts at 0 per batch and increments by 1 per write; all write outputs are registered.
REQ-017 Accepting a result with result_last=1 SHALL move to PAD after its final word.
REQ-018 Writing address 4095 without result_last SHALL close the batch as if last.
- result_ready stays 0 from that acceptance on.
- The move is to GAP, since no padding remains.
REQ-019 PAD SHALL write 32'h0 at successive addresses until the pad end (see REQ-027/028), then go to GAP.
- If the last word already landed on the pad end, PAD SHALL write nothing and go straight to GAP.
REQ-020 GAP SHALL hold WrEn=0 for exactly 2 cycles, covering the downstream word-gluing and BRAM write latency, then go to DONE.
REQ-021 DONE SHALL assert task_done for exactly 1 cycle and load batch_count with the accepted-result count, then go to DRAIN.
REQ-022 DRAIN SHALL wait for Full=1 and then Full=0, then go to IDLE, with no writes and result_ready=0.
REQ-023 result_valid with no transfer SHALL not change any state; result_data is sampled only on transfer.
REQ-024 Full=1 in IDLE SHALL hold IDLE; Full during COLLECT/PAD is ignored.

Reset
REQ-025 Asserting reset at any time, including mid-batch, SHALL immediately force state IDLE and clear the address, serializer and result count.
- Output values under reset: WrEn=0, WrAddr=0, WrDin=0, task_done=0, result_ready=0, batch_count=0.
- Partial batches are discarded.
REQ-026 After reset deasserts, the first accept SHALL occur no earlier than the second rising clk edge.

Configuration
REQ-027 With macro RESULT_COLLECTOR_PAD_FULL_EN defined, PAD SHALL fill through address 4095.
REQ-028 Without RESULT_COLLECTOR_PAD_FULL_EN, PAD SHALL fill only to the end of the current 16-word line (WrAddr[3:0]=4'hF).

Verification
REQ-029 Reset, Full=0, 3 results {64'h1111_2222_3333_4444, …} with last on the 3rd, macro off -> writes at addr 0..5 of 32'h1111_2222, 32'h3333_4444, …; zeros at 6..15; 2 idle cycles; task_done pulse; batch_count=3.
REQ-030 Same stimulus with macro on -> zero writes at 6..4095, then task_done; batch_count=3.
REQ-031 2048 results with result_valid held high and no last -> one write per cycle with no bubbles; close at addr 4095; no PAD; task_done; batch_count=2048.
REQ-032 After task_done, Full held high 100 cycles with result_valid=1 -> result_ready=0 throughout; after Full falls, the next batch restarts at WrAddr=0.
REQ-033 reset asserted on the 3rd word of a batch -> all outputs 0 in the same cycle, no task_done; a new batch after release starts at addr 0.
REQ-034 A result with result_last=1 whose final word lands on addr 15, macro off -> no PAD writes; task_done exactly 3 cycles after that write.
